// File: rtl/effect_gain_controller_pkg.sv
// effect_gain_controller_pkg: shared constants and helpers for the effect gain controller
//   DEBOUNCE_CYCLES_50M : 10 ms of key stability at 50 MHz
//   REPEAT_DELAY_50M    : 0.5 s hold before the first auto-repeat at 50 MHz
//   REPEAT_PERIOD_50M   : 0.1 s between auto-repeats at 50 MHz
//   mode_w()            : width of a mode index for a given number of modes (at least 1 bit)
package effect_ctrl_pkg;

    localparam int DEBOUNCE_CYCLES_50M = 500000;
    localparam int REPEAT_DELAY_50M    = 25000000;
    localparam int REPEAT_PERIOD_50M   = 5000000;

    function automatic int mode_w(input int modes);
        return (modes > 1) ? $clog2(modes) : 1;
    endfunction

endpackage

// File: rtl/effect_gain_controller_if.sv
// effect_gain_controller_if: key/switch inputs and gain outputs of the effect gain controller
//   key_up_n, key_down_n : raw active-low keys
//   mode_sw              : raw mode slide switches, highest set bit wins
//   gain_num, gain_den   : signed gain ratio of the active mode
//   mode                 : active mode index
//   changed              : one-cycle strobe when gain_num or mode takes a new value
//   master drives keys/switches, slave (the controller) drives the gain outputs
interface effect_gain_controller_if
    import effect_ctrl_pkg::*;
#(
    parameter int GAIN_W = 16,
    parameter int NUM_SW = 2
);
    localparam int MW = mode_w(NUM_SW + 1);

    logic                     key_up_n;
    logic                     key_down_n;
    logic [NUM_SW-1:0]        mode_sw;
    logic signed [GAIN_W-1:0] gain_num;
    logic signed [GAIN_W-1:0] gain_den;
    logic [MW-1:0]            mode;
    logic                     changed;

    modport master (
        output key_up_n, key_down_n, mode_sw,
        input  gain_num, gain_den, mode, changed
    );

    modport slave (
        input  key_up_n, key_down_n, mode_sw,
        output gain_num, gain_den, mode, changed
    );

endinterface

// File: rtl/effect_gain_controller_key_debouncer.sv
// key_debouncer: synchronises, debounces and auto-repeats one active-low key
//   CLK, RST   : clock and synchronous active-high reset
//   key_n      : raw active-low key
//   press      : one-cycle pulse in the cycle the debounced level falls
//   repeat_evt : one-cycle pulse REPEAT_DELAY cycles after press, then every REPEAT_PERIOD
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic press,
    output logic repeat_evt
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    logic          s1, s2, db;
    logic [DW-1:0] cnt;
    logic [HW-1:0] h, hn;
    logic          ph;
    logic          flip, fall, rise, fire;

    // ph selects the first-repeat delay (0) or the steady repeat period (1)
    always_comb begin
        flip = (s2 != db) && (cnt == DW'(DEBOUNCE_CYCLES - 1));
        fall = flip && !s2;
        rise = flip && s2;
        hn   = h + HW'(1);
        fire = !db && !rise && (hn == (ph ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            db         <= 1'b1;
            cnt        <= '0;
            h          <= '0;
            ph         <= 1'b0;
            press      <= 1'b0;
            repeat_evt <= 1'b0;
        end else begin
            s1         <= key_n;
            s2         <= s1;
            press      <= fall;
            repeat_evt <= fire;
            if (s2 != db) begin
                cnt <= flip ? '0 : cnt + DW'(1);
                if (flip)
                    db <= s2;
            end else begin
                cnt <= '0;
            end
            // hold counter runs only while held and not being released this cycle
            if (!db && !rise) begin
                h  <= fire ? '0 : hn;
                ph <= ph | fire;
            end else begin
                h  <= '0;
                ph <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/effect_gain_controller.sv
// effect_gain_controller: push-button per-mode saturating gain controller for gain-based effects
//   CLK, RST : clock and synchronous active-high reset
//   bus      : slave side of effect_gain_controller_if (keys and mode switches in,
//              gain_num/gain_den/mode/changed out)
module effect_gain_controller
    import effect_ctrl_pkg::*;
#(
    parameter int GAIN_W          = 16,
    parameter int GAIN_MIN        = 1,
    parameter int GAIN_MAX        = 50,
    parameter int GAIN_INIT       = 1,
    parameter int GAIN_STEP       = 1,
    parameter int GAIN_DEN        = 1,
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50M
) (
    input logic CLK,
    input logic RST,
    effect_gain_controller_if.slave bus
);
    localparam int MODES = NUM_SW + 1;
    localparam int MW    = mode_w(MODES);

    // widened by one bit so the step can never wrap before clamping
    localparam logic signed [GAIN_W:0] MAX_X  = (GAIN_W + 1)'(GAIN_MAX);
    localparam logic signed [GAIN_W:0] MIN_X  = (GAIN_W + 1)'(GAIN_MIN);
    localparam logic signed [GAIN_W:0] STEP_X = (GAIN_W + 1)'(GAIN_STEP);

    logic                     up_press, up_rep, dn_press, dn_rep;
    logic                     up_evt, dn_evt;
    logic [NUM_SW-1:0]        ms1, ms2;
    logic [MW-1:0]            mode_r, mode_next;
    logic signed [GAIN_W-1:0] gains [MODES];
    logic signed [GAIN_W-1:0] gain_num_r, g_cur, g_nxt;
    logic signed [GAIN_W:0]   g_x, up_x, dn_x, g_up, g_dn;
    logic                     changed_r;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_up (
        .CLK       (CLK),
        .RST       (RST),
        .key_n     (bus.key_up_n),
        .press     (up_press),
        .repeat_evt(up_rep)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_dn (
        .CLK       (CLK),
        .RST       (RST),
        .key_n     (bus.key_down_n),
        .press     (dn_press),
        .repeat_evt(dn_rep)
    );

    // highest set switch wins; later iterations override earlier ones
    always_comb begin
        mode_next = '0;
        for (int i = 0; i < NUM_SW; i++)
            if (ms2[i])
                mode_next = MW'(i + 1);
    end

    // opposing events in the same cycle cancel
    always_comb begin
        up_evt = up_press | up_rep;
        dn_evt = dn_press | dn_rep;
        g_cur  = gains[mode_r];
        g_x    = {g_cur[GAIN_W-1], g_cur};
        up_x   = g_x + STEP_X;
        dn_x   = g_x - STEP_X;
        g_up   = (up_x > MAX_X) ? MAX_X : up_x;
        g_dn   = (dn_x < MIN_X) ? MIN_X : dn_x;
        g_nxt  = (up_evt && !dn_evt) ? g_up[GAIN_W-1:0] :
                 (dn_evt && !up_evt) ? g_dn[GAIN_W-1:0] : g_cur;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ms1        <= '0;
            ms2        <= '0;
            mode_r     <= '0;
            gain_num_r <= GAIN_W'(GAIN_INIT);
            changed_r  <= 1'b0;
            for (int i = 0; i < MODES; i++)
                gains[i] <= GAIN_W'(GAIN_INIT);
        end else begin
            ms1            <= bus.mode_sw;
            ms2            <= ms1;
            mode_r         <= mode_next;
            gains[mode_r]  <= g_nxt;
            gain_num_r     <= g_cur;
            changed_r      <= (g_cur != gain_num_r) || (mode_next != mode_r);
        end
    end

    assign bus.gain_num = gain_num_r;
    assign bus.gain_den = GAIN_W'(GAIN_DEN);
    assign bus.mode     = mode_r;
    assign bus.changed  = changed_r;

endmodule

// File: tb/tb_effect_gain_controller.sv
// tb_effect_gain_controller: directed and randomized key/switch stimulus against an event-time model
module tb_effect_gain_controller;
    localparam int GW    = 16;
    localparam int DB    = 4;
    localparam int RD    = 20;
    localparam int RP    = 5;
    localparam int GMIN  = 1;
    localparam int GMAX  = 5;
    localparam int GINIT = 1;
    localparam int STEP  = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    effect_gain_controller_if #(.GAIN_W(GW), .NUM_SW(2)) bus ();

    effect_gain_controller #(
        .GAIN_W(GW), .GAIN_MIN(GMIN), .GAIN_MAX(GMAX), .GAIN_INIT(GINIT),
        .GAIN_STEP(STEP), .GAIN_DEN(1), .NUM_SW(2),
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL timeout reached before end of stimulus");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each key is described by its debounced level, the length of the current
    // run of disagreeing synchronised samples, and the edge at which it was pressed;
    // repeats are derived from the age of the press.
    int       g_m [3];
    int       gn_m, md_m, gn_new, md_new, age, n;
    bit       chg_m, mvalid;
    bit       ks1 [2], ks2 [2], db [2], pend [2], raw [2], was_low;
    int       run [2], pt [2];
    logic [1:0] sw1, sw2;

    always @(posedge CLK) begin
        n++;
        raw[0] = bus.key_up_n;
        raw[1] = bus.key_down_n;
        if (RST) begin
            for (int m = 0; m < 3; m++) g_m[m] = GINIT;
            gn_m  = GINIT;
            md_m  = 0;
            chg_m = 0;
            sw1   = 2'b00;
            sw2   = 2'b00;
            for (int k = 0; k < 2; k++) begin
                ks1[k] = 1; ks2[k] = 1; db[k] = 1; pend[k] = 0; run[k] = 0; pt[k] = 0;
            end
        end else begin
            gn_new = g_m[md_m];
            md_new = sw2[1] ? 2 : sw2[0] ? 1 : 0;
            chg_m  = (gn_new != gn_m) || (md_new != md_m);
            if (pend[0] && !pend[1])
                g_m[md_m] = (g_m[md_m] + STEP > GMAX) ? GMAX : g_m[md_m] + STEP;
            else if (pend[1] && !pend[0])
                g_m[md_m] = (g_m[md_m] - STEP < GMIN) ? GMIN : g_m[md_m] - STEP;
            gn_m = gn_new;
            md_m = md_new;
            for (int k = 0; k < 2; k++) begin
                pend[k] = 0;
                was_low = !db[k];
                if (ks2[k] != db[k]) begin
                    run[k]++;
                    if (run[k] == DB) begin
                        db[k]  = ks2[k];
                        run[k] = 0;
                        if (!db[k]) begin pend[k] = 1; pt[k] = n; end
                    end
                end else begin
                    run[k] = 0;
                end
                if (was_low && !db[k]) begin
                    age = n - pt[k];
                    if (age >= RD && (age - RD) % RP == 0) pend[k] = 1;
                end
                ks2[k] = ks1[k];
                ks1[k] = raw[k];
            end
            sw2 = sw1;
            sw1 = bus.mode_sw;
        end
        mvalid = 1;
    end

    always @(negedge CLK) begin
        if (mvalid) begin
            chk("gain_num", int'(bus.gain_num), gn_m);
            chk("mode", int'(bus.mode), md_m);
            chk("changed", int'(bus.changed), int'(chg_m));
            chk("gain_den", int'(bus.gain_den), 1);
        end
    end

    task automatic tick(input int c);
        repeat (c) @(negedge CLK);
    endtask

    task automatic tap(input bit up, input int lo, input int hi);
        if (up) bus.key_up_n = 1'b0; else bus.key_down_n = 1'b0;
        tick(lo);
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        tick(hi);
    endtask

    int cnt;

    initial begin
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        bus.mode_sw    = 2'b00;
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        cnt = 0;
        repeat (20) begin tick(1); cnt += int'(bus.changed); end
        chk("idle_gain", int'(bus.gain_num), 1);
        chk("idle_mode", int'(bus.mode), 0);
        chk("idle_changed_count", cnt, 0);

        // clean press: output moves 2+4+2 edges after the falling edge
        bus.key_up_n = 1'b0;
        tick(7);
        chk("press_before", int'(bus.gain_num), 1);
        tick(1);
        chk("press_after", int'(bus.gain_num), 2);
        chk("press_strobe", int'(bus.changed), 1);
        tick(1);
        chk("press_strobe_end", int'(bus.changed), 0);
        tick(1);
        bus.key_up_n = 1'b1;
        tick(15);

        // bounce every 2 cycles, then steady low: exactly one increment
        for (int i = 0; i < 10; i++) begin
            bus.key_up_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        bus.key_up_n = 1'b0;
        tick(12);
        bus.key_up_n = 1'b1;
        tick(15);
        chk("bounce_gain", int'(bus.gain_num), 3);

        // long hold: press and first repeat reach the ceiling, later repeats are silent
        cnt = 0;
        bus.key_up_n = 1'b0;
        repeat (60) begin tick(1); cnt += int'(bus.changed); end
        bus.key_up_n = 1'b1;
        repeat (10) begin tick(1); cnt += int'(bus.changed); end
        chk("hold_gain", int'(bus.gain_num), 5);
        chk("hold_changed_count", cnt, 2);

        repeat (6) tap(1'b0, 8, 10);
        chk("down_floor", int'(bus.gain_num), 1);

        // per-mode gains
        repeat (2) tap(1'b1, 8, 10);
        chk("mode0_gain", int'(bus.gain_num), 3);
        bus.mode_sw = 2'b10;
        tick(6);
        chk("mode2_sel", int'(bus.mode), 2);
        chk("mode2_init", int'(bus.gain_num), 1);
        repeat (2) tap(1'b1, 8, 10);
        chk("mode2_gain", int'(bus.gain_num), 3);
        bus.mode_sw = 2'b00;
        tick(6);
        chk("back_mode0", int'(bus.mode), 0);
        chk("back_gain0", int'(bus.gain_num), 3);
        bus.mode_sw = 2'b11;
        tick(6);
        chk("prio_mode", int'(bus.mode), 2);
        bus.mode_sw = 2'b00;
        tick(6);

        // both keys together cancel
        bus.key_up_n   = 1'b0;
        bus.key_down_n = 1'b0;
        tick(10);
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        tick(15);
        chk("both_gain", int'(bus.gain_num), 3);

        // reset mid-hold, key still held afterwards
        bus.key_up_n = 1'b0;
        tick(30);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        chk("rst_gain", int'(bus.gain_num), 1);
        tick(6);
        chk("rst_press_before", int'(bus.gain_num), 1);
        tick(1);
        chk("rst_press_after", int'(bus.gain_num), 2);
        bus.key_up_n = 1'b1;
        tick(15);

        // randomized levels, dwell times, switches and occasional resets
        for (int s = 0; s < 200; s++) begin
            bus.key_up_n   = 1'($urandom_range(0, 1));
            bus.key_down_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) bus.mode_sw = 2'($urandom_range(0, 3));
            RST = ($urandom_range(0, 40) == 0);
            tick($urandom_range(1, 30));
        end
        RST = 1'b0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/effect_gain_controller.md
Name: effect_gain_controller

Overview:
Generalised push-button gain/mode controller for the effects chain, driving the distortion stage and other gain-based effect stages.
- Debounces two active-low KEY inputs and generates press and auto-repeat events.
- Keeps a separate saturating gain value for each mode.
- Selects the mode from a parametrised bank of priority-encoded slide switches.
- Outputs the active mode's gain as a numerator/denominator pair, plus a change strobe for downstream logic.

Parameters:
- GAIN_W, 16: signed width of gain_num and gain_den.
- GAIN_MIN, 1: lower saturation bound.
- GAIN_MAX, 50: upper saturation bound.
- GAIN_INIT, 1: reset value of every mode's gain. Must satisfy GAIN_MIN ≤ GAIN_INIT ≤ GAIN_MAX.
- GAIN_STEP, 1: increment/decrement applied per event. Must be ≥ 1.
- GAIN_DEN, 1: constant denominator presented on gain_den.
- NUM_SW, 2: number of mode switches. Number of modes is NUM_SW+1.
- DEBOUNCE_CYCLES, 500000: stable cycles required to accept a key level change. 10 ms at 50 MHz.
- REPEAT_DELAY, 25000000: hold cycles after a press before the first repeat event.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat events.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- key_up_n  input  1  raw KEY, active low; increments gain.
- key_down_n  input  1  raw KEY, active low; decrements gain.
- mode_sw  input  NUM_SW  raw slide switches; highest set bit wins.
- gain_num  output  GAIN_W  signed gain of the active mode (registered).
- gain_den  output  GAIN_W  signed, constant GAIN_DEN.
- mode  output  $clog2(NUM_SW+1)  active mode index (registered).
- changed  output  1  one-cycle strobe when gain_num or mode changes.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - All per-mode gains = GAIN_INIT; gain_num = GAIN_INIT; mode = 0; changed = 0.
  - Synchronisers and debounced levels = 1 (released); all counters = 0.
  - RST has priority over every other input.
- Input conditioning:
  - Each key and each mode_sw bit passes through a 2-flop synchroniser.
- Debounce, per key:
  - The debounced level takes the synchronised level after that level has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back restarts the counter at 0.
- Press event:
  - A one-cycle pulse is issued in the cycle the debounced level goes 1→0.
  - A key held through reset release produces one press, 2+DEBOUNCE_CYCLES cycles after RST deasserts.
- Auto-repeat:
  - While the debounced level stays 0, a hold counter runs.
  - First repeat pulse after REPEAT_DELAY cycles from the press, then one every REPEAT_PERIOD cycles.
  - Releasing the key clears the hold counter.
- Mode decode:
  - mode = i+1, where i is the highest set synchronised mode_sw bit; mode = 0 if no bit is set.
  - mode is registered and updates 3 cycles after a mode_sw change. Switches are not debounced.
- Gain update:
  - Each step event applies to the gain of the current (registered) mode in the cycle after the event pulse.
  - Up event: g = min(g+GAIN_STEP, GAIN_MAX).
  - Down event: g = max(g−GAIN_STEP, GAIN_MIN).
  - Arithmetic is done at GAIN_W+1 bits before clamping, so there is no wrap-around.
- Simultaneous up and down events in the same cycle: no gain change. Both keys held: repeats continue to cancel.
- Mode change with an event in the same cycle: the event applies to the old mode's gain.
- gain_num output:
  - Registered; equals the stored gain of the registered mode.
  - Updates one cycle after either the gain update or the mode change.
- gain_den: driven constant GAIN_DEN at all times, including during reset.
- changed strobe:
  - Asserted for exactly one cycle, in the cycle gain_num or mode takes a new value.
  - Not asserted when a clamp leaves the gain unchanged.
- Per-mode gains are retained across mode switches and cleared only by RST.
- Reset mid-hold: the repeat sequence is abandoned; counting restarts from debounce after reset.

Decomposition:
- Package effect_ctrl_pkg holds:
  - the mode index width function;
  - the default timing constants: DEBOUNCE_CYCLES_50M, REPEAT_DELAY_50M, REPEAT_PERIOD_50M.
- Sub-module key_debouncer, instantiated once per key:
  - contains the synchroniser, debounce counter, press pulse and auto-repeat counter;
  - ports: CLK, RST, key_n, press, repeat_evt.
- The top level contains the mode decoder, gain register array, clamp arithmetic and output registers.

Test Plan:
Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, GAIN_MAX=5, NUM_SW=2.
- Reset then idle: gain_num=1, gain_den=1, mode=0, changed never asserted.
- Clean key_up_n press of 10 cycles: gain_num 1→2 exactly 2+4+2 cycles after the falling edge; changed high for 1 cycle.
- key_up_n bouncing 0/1 every 2 cycles for 20 cycles, then steady low: exactly one increment.
- key_up_n held 60 cycles: press plus repeats at hold cycles 20, 25, 30; gain saturates at 5; further repeats produce no changed strobe. Then key_down_n presses down to 1, and extra presses keep 1.
- Set gain 3 in mode 0, set mode_sw=2'b10 (mode 2), press up twice: mode 2 gain=3. Return to mode_sw=0: gain_num=3 and mode=0, with changed pulsed on each switch. mode_sw=2'b11 yields mode 2.
- Both keys pressed in the same cycle: gain unchanged. RST asserted mid-hold: all gains restore to 1, and one press is seen after debounce if the key is still held.
